prog_clk_divider: RTL



---
 rtl/prog_clk_divider.sv | 133 +++++++++++++
 1 files changed

// File: rtl/prog_clk_divider.sv
// prog_clk_divider: multi-channel programmable divider producing a registered
// divided clock and a period-start tick per channel. Ratio/duty writes land in
// a shadow copy and are promoted to the active copy only at a period boundary,
// on sync, or every cycle while the channel is disabled.
module prog_clk_divider #(
  parameter  int NUM_CH   = 4,
  parameter  int CNT_W    = 16,
  parameter  int DEF_DIV  = 16,
  parameter  int DEF_DUTY = 4,
  parameter  int DEF_EN   = 1,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [CNT_W-1:0]  cfg_div_i,
  input  logic [CNT_W-1:0]  cfg_duty_i,
  input  logic              cfg_en_i,
  input  logic              sync_i,
  output logic [NUM_CH-1:0] clk_div_o,
  output logic [NUM_CH-1:0] tick_o,
  output logic [NUM_CH-1:0] pending_o,
  output logic              cfg_err_o
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] DUTY_RST = CNT_W'(DEF_DUTY);
  localparam logic             EN_RST   = (DEF_EN != 0);

  logic [CNT_W-1:0]  cnt_q      [NUM_CH];
  logic [CNT_W-1:0]  cnt_d      [NUM_CH];
  logic [CNT_W-1:0]  div_act_q  [NUM_CH];
  logic [CNT_W-1:0]  div_act_d  [NUM_CH];
  logic [CNT_W-1:0]  duty_act_q [NUM_CH];
  logic [CNT_W-1:0]  duty_act_d [NUM_CH];
  logic [CNT_W-1:0]  div_sh_q   [NUM_CH];
  logic [CNT_W-1:0]  div_sh_d   [NUM_CH];
  logic [CNT_W-1:0]  duty_sh_q  [NUM_CH];
  logic [CNT_W-1:0]  duty_sh_d  [NUM_CH];
  logic [NUM_CH-1:0] en_q, en_d;
  logic [NUM_CH-1:0] clk_div_q, clk_div_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] wr_sel;
  logic              cfg_err_q, cfg_err_d;
  logic              wr_ok;

  assign wr_ok = cfg_we_i && (int'(cfg_ch_i) < NUM_CH) && (cfg_div_i >= TWO);

  // Decode the accepted write into a one-hot channel select.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i] = wr_ok && (int'(cfg_ch_i) == i);
    end
  end

  // Per-channel next state. The shadow seen here already includes a same-edge
  // write, so promotions at wrap/sync/disable pick up the newest values. The
  // enable used for this edge is the newly written one, so enable changes act
  // without waiting for a boundary.
  always_comb begin
    cfg_err_d = cfg_we_i && !wr_ok;
    for (int i = 0; i < NUM_CH; i++) begin
      div_sh_d[i]   = wr_sel[i] ? cfg_div_i  : div_sh_q[i];
      duty_sh_d[i]  = wr_sel[i] ? cfg_duty_i : duty_sh_q[i];
      en_d[i]       = wr_sel[i] ? cfg_en_i   : en_q[i];
      cnt_d[i]      = cnt_q[i];
      div_act_d[i]  = div_act_q[i];
      duty_act_d[i] = duty_act_q[i];
      clk_div_d[i]  = 1'b0;
      tick_d[i]     = 1'b0;
      pending_d[i]  = pending_q[i];
      if (!en_d[i] || sync_i) begin
        cnt_d[i]      = '0;
        div_act_d[i]  = div_sh_d[i];
        duty_act_d[i] = duty_sh_d[i];
        pending_d[i]  = 1'b0;
      end else begin
        clk_div_d[i] = (cnt_q[i] < duty_act_q[i]);
        tick_d[i]    = (cnt_q[i] == '0);
        if (cnt_q[i] == (div_act_q[i] - ONE)) begin
          cnt_d[i]      = '0;
          div_act_d[i]  = div_sh_d[i];
          duty_act_d[i] = duty_sh_d[i];
          pending_d[i]  = 1'b0;
        end else begin
          cnt_d[i]     = cnt_q[i] + ONE;
          pending_d[i] = pending_q[i] | wr_sel[i];
        end
      end
    end
  end

  // State registers with asynchronous return to the default configuration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]      <= '0;
        div_act_q[i]  <= DIV_RST;
        duty_act_q[i] <= DUTY_RST;
        div_sh_q[i]   <= DIV_RST;
        duty_sh_q[i]  <= DUTY_RST;
      end
      en_q      <= {NUM_CH{EN_RST}};
      clk_div_q <= '0;
      tick_q    <= '0;
      pending_q <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i]      <= cnt_d[i];
        div_act_q[i]  <= div_act_d[i];
        duty_act_q[i] <= duty_act_d[i];
        div_sh_q[i]   <= div_sh_d[i];
        duty_sh_q[i]  <= duty_sh_d[i];
      end
      en_q      <= en_d;
      clk_div_q <= clk_div_d;
      tick_q    <= tick_d;
      pending_q <= pending_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign clk_div_o = clk_div_q;
  assign tick_o    = tick_q;
  assign pending_o = pending_q;
  assign cfg_err_o = cfg_err_q;

endmodule
